// File: rtl/enemy_fire_if.sv
// Bundle between the enemy formation logic (master) and the fire scheduler (slave):
// per-requester fire requests and positions in, launch pulses and slot status out.
interface enemy_fire_if #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_SLOTS = 2
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic                   enable;
    logic [NUM_REQ-1:0]     fire_req;
    logic [NUM_REQ*10-1:0]  req_x;
    logic [NUM_REQ*10-1:0]  req_y;
    logic [NUM_SLOTS-1:0]   slot_done;
    logic [NUM_SLOTS-1:0]   launch;
    logic [9:0]             launch_x;
    logic [9:0]             launch_y;
    logic [NUM_SLOTS-1:0]   slot_busy;
    logic [IDX_W-1:0]       grant_id;
    logic                   cooldown_active;

    modport master (
        output enable, fire_req, req_x, req_y, slot_done,
        input  launch, launch_x, launch_y, slot_busy, grant_id, cooldown_active
    );

    modport slave (
        input  enable, fire_req, req_x, req_y, slot_done,
        output launch, launch_x, launch_y, slot_busy, grant_id, cooldown_active
    );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Round-robin enemy fire arbiter feeding a pool of missile slots, with a launch cooldown.
// Optional ENEMY_FIRE_LFSR_EN randomises the next round-robin start and the cooldown length.
module enemy_fire_scheduler #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_SLOTS = 2,
    parameter int COOLDOWN  = 30,
    parameter int Y_OFFSET  = 8,
    parameter int Y_LIMIT   = 287
) (
    input  logic         frame_clk,
    input  logic         Reset,
    enemy_fire_if.slave  fire_bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // Wide enough for COOLDOWN plus the largest random extension.
    localparam int CNT_W = $clog2(COOLDOWN + 17);

    localparam logic [CNT_W-1:0] CNT_COOLDOWN = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [10:0]      Y_OFF11      = 11'(Y_OFFSET);
    localparam logic [10:0]      Y_LIM11      = 11'(Y_LIMIT);
    localparam logic [9:0]       Y_OFF10      = 10'(Y_OFFSET);

    typedef enum logic [1:0] {
        ST_COOL   = 2'd0,
        ST_ARB    = 2'd1,
        ST_LAUNCH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0] slot_busy_q, slot_busy_d;
    logic [NUM_SLOTS-1:0] launch_q, launch_d;
    logic [9:0]           launch_x_q, launch_x_d;
    logic [9:0]           launch_y_q, launch_y_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;

    logic [9:0]           req_x_s [NUM_REQ];
    logic [9:0]           req_y_s [NUM_REQ];
    logic [NUM_REQ-1:0]   eligible_s;
    logic                 win_found_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic                 slot_found_s;
    logic [NUM_SLOTS-1:0] slot_sel_s;
    logic [IDX_W-1:0]     rr_next_s;
    logic [CNT_W-1:0]     cnt_reload_s;

    // Launch height sum is kept at 11 bits so a low requester never wraps back on screen.
    function automatic logic is_eligible(input logic req, input logic [9:0] y);
        logic [10:0] sum;
        sum = {1'b0, y} + Y_OFF11;
        is_eligible = req && (sum < Y_LIM11);
    endfunction

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        rr_index = base + off[IDX_W-1:0];
    endfunction

    // Unpack requester positions and qualify requests.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x_s[i]    = fire_bus.req_x[10*i +: 10];
            req_y_s[i]    = fire_bus.req_y[10*i +: 10];
            eligible_s[i] = is_eligible(fire_bus.fire_req[i], fire_bus.req_y[10*i +: 10]);
        end
    end

    // Round-robin pick: first eligible requester at or after rr_ptr.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_idx_s   = (!win_found_s && eligible_s[rr_index(rr_ptr_q, k)])
                          ? rr_index(rr_ptr_q, k) : win_idx_s;
            win_found_s = win_found_s | eligible_s[rr_index(rr_ptr_q, k)];
        end
    end

    // Lowest-index free slot as a one-hot select.
    always_comb begin
        slot_found_s = 1'b0;
        slot_sel_s   = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_sel_s[s] = !slot_busy_q[s] && !slot_found_s;
            slot_found_s  = slot_found_s | !slot_busy_q[s];
        end
    end

`ifdef ENEMY_FIRE_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, free-running every frame.
    always_comb begin
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rr_next_s    = lfsr_q[IDX_W-1:0];
        cnt_reload_s = CNT_COOLDOWN + CNT_W'(lfsr_q[3:0]);
    end

    // LFSR state register.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Deterministic scheduling: continue after the last winner, fixed cooldown.
    always_comb begin
        rr_next_s    = grant_id_q + IDX_W'(1);
        cnt_reload_s = CNT_COOLDOWN;
    end
`endif

    // Next-state and output decode for the COOL/ARB/LAUNCH sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        slot_busy_d = slot_busy_q & ~fire_bus.slot_done;
        launch_d    = '0;
        launch_x_d  = launch_x_q;
        launch_y_d  = launch_y_q;
        grant_id_d  = grant_id_q;

        case (state_q)
            ST_COOL: begin
                // Leaving when the decremented count reaches zero makes COOLDOWN=N
                // exactly N cycles here, with COOLDOWN=0 still spending one cycle.
                if (fire_bus.enable) begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ARB: begin
                if (!fire_bus.enable) begin
                    cnt_d   = CNT_COOLDOWN;
                    state_d = ST_COOL;
                end else if (win_found_s && slot_found_s) begin
                    launch_d    = slot_sel_s;
                    launch_x_d  = req_x_s[win_idx_s];
                    launch_y_d  = req_y_s[win_idx_s] + Y_OFF10;
                    slot_busy_d = slot_busy_d | slot_sel_s;
                    grant_id_d  = win_idx_s;
                    state_d     = ST_LAUNCH;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_LAUNCH: begin
                rr_ptr_d = rr_next_s;
                cnt_d    = cnt_reload_s;
                state_d  = ST_COOL;
            end
            default: begin
                cnt_d   = CNT_COOLDOWN;
                state_d = ST_COOL;
            end
        endcase
    end

    // Sequencer and output registers; reset is effective immediately, even mid-launch.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_COOL;
            cnt_q       <= CNT_COOLDOWN;
            rr_ptr_q    <= '0;
            slot_busy_q <= '0;
            launch_q    <= '0;
            launch_x_q  <= 10'd0;
            launch_y_q  <= 10'd0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            slot_busy_q <= slot_busy_d;
            launch_q    <= launch_d;
            launch_x_q  <= launch_x_d;
            launch_y_q  <= launch_y_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign fire_bus.launch          = launch_q;
    assign fire_bus.launch_x        = launch_x_q;
    assign fire_bus.launch_y        = launch_y_q;
    assign fire_bus.slot_busy       = slot_busy_q;
    assign fire_bus.grant_id        = grant_id_q;
    assign fire_bus.cooldown_active = (state_q == ST_COOL);
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench for enemy_fire_scheduler (NUM_REQ=8, NUM_SLOTS=2, COOLDOWN=4).
module tb_enemy_fire_scheduler;
    localparam int NUM_REQ   = 8;
    localparam int NUM_SLOTS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    enemy_fire_if #(.NUM_REQ(NUM_REQ), .NUM_SLOTS(NUM_SLOTS)) bus ();

    enemy_fire_scheduler #(
        .NUM_REQ(NUM_REQ), .NUM_SLOTS(NUM_SLOTS), .COOLDOWN(4),
        .Y_OFFSET(8), .Y_LIMIT(287)
    ) dut (
        .frame_clk(clk),
        .Reset(rst),
        .fire_bus(bus)
    );

    typedef struct {
        int slot;
        int x;
        int y;
        int grant;
        int busy;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc;
    int   errors = 0;
    int   checks = 0;

    // Edge count since reset release; a launch registered at edge L is seen with cyc == L.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int slot, input int x, input int y, input int grant,
                        input int busy, input int at_cyc);
        exp_t e;
        e.slot = slot; e.x = x; e.y = y; e.grant = grant; e.busy = busy; e.cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    // Monitor: every launch pulse is matched against the next expected launch.
    always @(negedge clk) begin
        if (!rst && bus.launch != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_launch", int'(bus.launch), 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("launch_slot", int'(bus.launch), mon_e.slot);
                chk("launch_x", int'(bus.launch_x), mon_e.x);
                chk("launch_y", int'(bus.launch_y), mon_e.y);
                chk("grant_id", int'(bus.grant_id), mon_e.grant);
                chk("slot_busy", int'(bus.slot_busy), mon_e.busy);
                chk("launch_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic go_to(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (cyc != n) chk("go_to_timeout", cyc, n);
    endtask

    task automatic set_req(input int i, input int x, input int y);
        bus.req_x[10*i +: 10] = 10'(x);
        bus.req_y[10*i +: 10] = 10'(y);
    endtask

    task automatic clear_inputs();
        bus.enable    = 1'b1;
        bus.fire_req  = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.slot_done = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_launch", int'(bus.launch), 0);
        chk("rst_launch_x", int'(bus.launch_x), 0);
        chk("rst_launch_y", int'(bus.launch_y), 0);
        chk("rst_slot_busy", int'(bus.slot_busy), 0);
        chk("rst_grant_id", int'(bus.grant_id), 0);
        chk("rst_cooldown", int'(bus.cooldown_active), 1);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: single request after reset.
        clear_inputs();
        bus.fire_req = 8'h01;
        set_req(0, 100, 50);
        push(1, 100, 58, 0, 1, 5);
        do_reset();
        go_to(7);

        // 2: all requesting, slots exhaust, ARB stalls, slot_done frees slot 0.
        clear_inputs();
        bus.fire_req = 8'hFF;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 40*i + 20, 30*i + 10);
        push(1, 20, 18, 0, 1, 5);
        push(2, 60, 48, 1, 3, 11);
        do_reset();
        go_to(18);
        chk("t2_stall_launch", int'(bus.launch), 0);
        chk("t2_stall_busy", int'(bus.slot_busy), 3);
        chk("t2_stall_in_arb", int'(bus.cooldown_active), 0);
        go_to(20);
        push(1, 100, 78, 2, 3, 22);
        bus.slot_done = 2'b01;
        go_to(21);
        bus.slot_done = 2'b00;
        go_to(24);

        // 3: requesters 0 and 7 alternate; slot retired during each LAUNCH cycle.
        clear_inputs();
        bus.fire_req = 8'h81;
        set_req(0, 100, 50);
        set_req(7, 600, 100);
        push(1, 100, 58, 0, 1, 5);
        push(1, 600, 108, 7, 1, 11);
        push(1, 100, 58, 0, 1, 17);
        push(1, 600, 108, 7, 1, 23);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            go_to(5 + 6*k);
            bus.slot_done = 2'b01;
            go_to(6 + 6*k);
            bus.slot_done = 2'b00;
        end
        go_to(25);

        // 4: Y limit boundary (280 and 279 blocked, 278 allowed).
        clear_inputs();
        bus.fire_req = 8'h08;
        set_req(3, 333, 280);
        push(1, 333, 286, 3, 1, 9);
        do_reset();
        go_to(6);
        chk("t4_blocked_280_busy", int'(bus.slot_busy), 0);
        chk("t4_blocked_280_arb", int'(bus.cooldown_active), 0);
        set_req(3, 333, 279);
        go_to(8);
        chk("t4_blocked_279_busy", int'(bus.slot_busy), 0);
        chk("t4_blocked_279_launch", int'(bus.launch), 0);
        set_req(3, 333, 278);
        go_to(11);

        // 5: asynchronous reset in the middle of a LAUNCH cycle.
        clear_inputs();
        bus.fire_req = 8'h20;
        set_req(5, 500, 200);
        do_reset();
        go_to(5);
        chk("t5_pre_launch", int'(bus.launch), 1);
        chk("t5_pre_grant", int'(bus.grant_id), 5);
        chk("t5_pre_launch_y", int'(bus.launch_y), 208);
        rst = 1'b1;
        #1;
        chk("t5_async_launch", int'(bus.launch), 0);
        chk("t5_async_busy", int'(bus.slot_busy), 0);
        chk("t5_async_grant", int'(bus.grant_id), 0);
        chk("t5_async_cool", int'(bus.cooldown_active), 1);

        // 6: enable dropped in ARB, later raised.
        clear_inputs();
        bus.fire_req = 8'h01;
        set_req(0, 100, 50);
        do_reset();
        go_to(4);
        chk("t6_in_arb", int'(bus.cooldown_active), 0);
        bus.enable = 1'b0;
        go_to(7);
        chk("t6_disabled_cool", int'(bus.cooldown_active), 1);
        chk("t6_disabled_busy", int'(bus.slot_busy), 0);
        go_to(9);
        push(1, 100, 58, 0, 1, 14);
        bus.enable = 1'b1;
        go_to(16);
        bus.fire_req = 8'h00;
        go_to(18);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
- Decides which enemy fires next and which enemy-missile slot carries the shot.
- Round-robin arbitrates per-enemy fire requests onto a pool of NUM_SLOTS missile slots, with a cooldown between launches.
- Each launch is a one-cycle pulse carrying the start X/Y to the chosen slot's datapath.
- Sits between the enemy formation logic and the enemy-missile slot instances, all on frame_clk.

Parameters:
NUM_REQ, 8, number of enemy requesters (columns); power of two, 2..16
NUM_SLOTS, 2, number of enemy missile slots, 1..4
COOLDOWN, 30, frames between a launch and the next arbitration
Y_OFFSET, 8, pixels added to requester Y to get launch Y
Y_LIMIT, 287, requests whose req_y+Y_OFFSET >= Y_LIMIT are ignored

Ports:
frame_clk  in  1  sole clock; all state changes on rising edge
Reset  in  1  asynchronous, active-high reset
enable  in  1  game running; low suppresses new launches
fire_req  in  NUM_REQ  per-requester fire request, level
req_x  in  NUM_REQ*10  packed X; requester i at [10i+9:10i]
req_y  in  NUM_REQ*10  packed Y, same packing
slot_done  in  NUM_SLOTS  one-cycle pulse: slot's missile retired (hit or off-screen)
launch  out  NUM_SLOTS  one-hot one-cycle launch pulse
launch_x  out  10  start X, valid while launch != 0
launch_y  out  10  start Y, valid while launch != 0
slot_busy  out  NUM_SLOTS  slot carries a live missile
grant_id  out  clog2(NUM_REQ)  last granted requester
cooldown_active  out  1  high while FSM in COOL

Behaviour:
- Reset (async, any time, including mid-LAUNCH): state=COOL, cnt=COOLDOWN, rr_ptr=0, slot_busy=0, launch=0, launch_x=launch_y=0, grant_id=0. cooldown_active=1.
- Eligible requester i: fire_req[i]=1 and req_y[i]+Y_OFFSET < Y_LIMIT. The sum is computed at 11 bits, so there is no wrap.
- Free slot: slot_busy[s]=0, sampled at the current cycle. A slot freed by slot_done is usable from the next cycle.
- COOL:
  - enable=1: cnt decrements each cycle; at cnt==0, next state is ARB.
  - enable=0: cnt holds.
  - COOLDOWN=0 gives exactly one cycle in COOL.
- ARB:
  - If any eligible requester and any free slot:
    - winner = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    - slot = lowest-index free slot.
    - Register launch one-hot, launch_x=req_x[winner], launch_y=req_y[winner]+Y_OFFSET[9:0].
    - Set slot_busy[slot]=1 and grant_id=winner; next state LAUNCH.
  - Otherwise stay in ARB; no cooldown accrues.
- LAUNCH (exactly one cycle):
  - Outputs from ARB are visible; rr_ptr=winner+1 mod NUM_REQ; cnt=COOLDOWN.
  - Next state COOL; launch returns to 0 on exit.
- Latency: eligible request present in ARB cycle N -> launch pulse during cycle N+1.
- slot_done[s]:
  - Clears slot_busy[s] at the next edge, in any state.
  - Ignored if slot_busy[s]=0.
  - If asserted during LAUNCH for the just-launched slot, it clears that slot (immediate retirement is legal).
- enable=0 in ARB: go to COOL with cnt=COOLDOWN. A LAUNCH already in progress always completes.
- fire_req changing during LAUNCH has no effect on the issued launch.
- launch_x/launch_y hold their last values when launch=0.

Optional Feature:
ENEMY_FIRE_LFSR_EN:
- When defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on Reset) advances every frame_clk.
  - In LAUNCH, rr_ptr = lfsr[clog2(NUM_REQ)-1:0] instead of winner+1.
  - cnt reload = COOLDOWN + lfsr[3:0].
- When undefined: no LFSR; scheduling is fully deterministic as above.

Test Plan:
(NUM_REQ=8, NUM_SLOTS=2, COOLDOWN=4, Y_OFFSET=8, Y_LIMIT=287, macro undefined)
1. Release Reset with enable=1, fire_req=8'h01, req_x[0]=100, req_y[0]=50 -> 4 COOL cycles, 1 ARB, then launch=2'b01, launch_x=100, launch_y=58, grant_id=0, slot_busy=2'b01.
2. fire_req=8'hFF held, no slot_done -> launches grant 0 (slot 0), then 1 (slot 1). ARB then stalls, launch stays 0. Pulse slot_done=2'b01 -> next launch grants 2 on slot 0.
3. fire_req=8'h81 steady, slot_done pulsed after each launch -> grants alternate 0,7,0,7; each launch is separated by 4 cooldown cycles plus 1 ARB cycle.
4. req_y[3]=280, fire_req=8'h08 -> no launch (280+8>=287). Change req_y[3]=278 -> launch_y=286.
5. Assert Reset during LAUNCH -> launch, slot_busy and grant_id go to 0 immediately, without waiting for a clock edge. cooldown_active=1.
6. enable=0 while in ARB with requests pending -> no launch, FSM in COOL with cnt held at 4. Raise enable -> launch after 4 COOL cycles + 1 ARB cycle.
